// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encoding, FSM states and size helper for the data-memory responder
package dmem_pkg;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   function automatic logic [3:0] size_bytes(input logic [1:0] sz);
      return 4'd1 << sz;
   endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian lane merge for stores and lane extract/extend for loads
//   rd_i     stored doubleword          off_i   byte offset within doubleword
//   size_i   access size (SZ_*)         uns_i   1 = zero-extend loads
//   wdata_i  right-aligned store data   wr_o    merged doubleword   ld_o  extended load
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [63:0] rd_i,
   input  logic [2:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [63:0] wdata_i,
   output logic [63:0] wr_o,
   output logic [63:0] ld_o
);
   logic [5:0]  sh;
   logic [63:0] m;
   logic [63:0] lane;
   assign sh = {off_i, 3'b000};
   assign m = (size_i == SZ_D ? 64'hFFFF_FFFF_FFFF_FFFF
                              : (64'd1 << {size_bytes(size_i), 3'b000}) - 64'd1) << sh;
   assign wr_o = (rd_i & ~m) | ((wdata_i << sh) & m);
   assign lane = rd_i >> sh;
   assign ld_o = size_i == SZ_B ? {{56{~uns_i & lane[7]}}, lane[7:0]}
               : size_i == SZ_H ? {{48{~uns_i & lane[15]}}, lane[15:0]}
               : size_i == SZ_W ? {{32{~uns_i & lane[31]}}, lane[31:0]}
               : lane;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle load/store data memory with one outstanding request
//   clk_i/rst_i             clock, async active-high reset
//   req_valid_i/req_ready_o request handshake; req_write_i, req_size_i, req_unsigned_i,
//                           req_addr_i, req_wdata_i describe the access
//   rsp_valid_o/rsp_ready_i response handshake; rsp_rdata_o load result, rsp_err_o fault
//   DMEM_ERR_CHECK_EN       when defined, misaligned/out-of-range requests fault;
//                           otherwise addresses are aligned down and wrap modulo DEPTH
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [63:0]       req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [63:0]       rsp_rdata_o,
   output logic              rsp_err_o
);
   localparam int IW = $clog2(DEPTH);
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [63:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              write_q, uns_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [63:0]       wdata_q;
   logic [63:0]       mem_q [DEPTH];
   logic              c_write, c_uns, commit, fault;
   logic [1:0]        c_size;
   logic [ADDR_W-1:0] c_addr;
   logic [63:0]       c_wdata, merged, loaded;
   logic [2:0]        lsb_m, off;
   logic [IW-1:0]     idx;
   // With LATENCY==1 the commit edge is the accept edge, so the live request feeds the datapath in IDLE.
   assign c_write = state_q == IDLE ? req_write_i    : write_q;
   assign c_uns   = state_q == IDLE ? req_unsigned_i : uns_q;
   assign c_size  = state_q == IDLE ? req_size_i     : size_q;
   assign c_addr  = state_q == IDLE ? req_addr_i     : addr_q;
   assign c_wdata = state_q == IDLE ? req_wdata_i    : wdata_q;
   assign lsb_m   = 3'(size_bytes(c_size) - 4'd1);
   assign idx     = c_addr[IW+2:3];
`ifdef DMEM_ERR_CHECK_EN
   assign off   = c_addr[2:0];
   assign fault = |(c_addr[2:0] & lsb_m) || |c_addr[ADDR_W-1:IW+3];
`else
   logic unused_addr;
   assign off         = c_addr[2:0] & ~lsb_m;
   assign fault       = 1'b0;
   assign unused_addr = ^c_addr[ADDR_W-1:IW+3];
`endif
   dmem_lane_align u_align (
      .rd_i    (mem_q[idx]),
      .off_i   (off),
      .size_i  (c_size),
      .uns_i   (c_uns),
      .wdata_i (c_wdata),
      .wr_o    (merged),
      .ld_o    (loaded)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: if (req_valid_i) begin
            state_d = LATENCY == 1 ? RESP : WAIT;
            cnt_d   = 4'(LATENCY - 1);
            commit  = LATENCY == 1;
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
               commit  = 1'b1;
            end
         end
         RESP: if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (commit) begin
         rdata_d = (c_write || fault) ? 64'd0 : loaded;
         err_d   = fault;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   // Request latches and storage are never reset; a write is suppressed while reset is held.
   always_ff @(posedge clk_i) begin
      if (state_q == IDLE && req_valid_i) begin
         write_q <= req_write_i;
         uns_q   <= req_unsigned_i;
         size_q  <= req_size_i;
         addr_q  <= req_addr_i;
         wdata_q <= req_wdata_i;
      end
      if (commit && c_write && !fault && !rst_i) mem_q[idx] <= merged;
   end
   assign req_ready_o = state_q == IDLE;
   assign rsp_valid_o = state_q == RESP;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
endmodule
